adma_data_fifo: RTL and testbench
=================================

# adma_data_fifo

Single-clock synchronous data FIFO between the ADMA transfer engine and the SD card data path. It buffers 32-bit words in both directions. It drives the `fifo_full`/`fifo_empty` flags that throttle the ADMA transfer state, and it reports fill level, thresholds and sticky error status to the host register block. One instance is used per direction, and `direction` selects which instance the ADMA addresses.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width.
- `DEPTH`, 16: number of entries. Must be a power of two and at least 4.
- `AF_LEVEL`, 12: `almost_full` asserts when level ≥ `AF_LEVEL`.
- `AE_LEVEL`, 4: `almost_empty` asserts when level ≤ `AE_LEVEL`.

Ports:
- One clock; reset is asynchronous and active-low.
- `CLK`  in  1  sole clock; all state changes on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `fifo_write`  in  1  push request.
- `data_to_fifo`  in  DATA_WIDTH  push data.
- `fifo_read`  in  1  pop request.
- `data_from_fifo`  out  DATA_WIDTH  registered pop data.
- `fifo_full`  out  1  level == DEPTH.
- `fifo_empty`  out  1  level == 0.
- `almost_full`  out  1  level ≥ AF_LEVEL.
- `almost_empty`  out  1  level ≤ AE_LEVEL.
- `level`  out  log2(DEPTH)+1  current occupancy.
- `flush`  in  1  synchronous clear of contents.
- `clear_status`  in  1  clears the sticky error flags.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- Storage is a DEPTH×DATA_WIDTH array.
- Write pointer `wp` and read pointer `rp` are each log2(DEPTH)+1 bits.
  - The low bits index the array; the MSB is the wrap bit.
  - Pointers increment modulo 2·DEPTH.
- Level is `wp − rp` computed modulo 2·DEPTH.
  - Full: low bits equal and MSBs differ.
  - Empty: pointers equal.
- Status flags (`fifo_full`, `fifo_empty`, `almost_full`, `almost_empty`, `level`) are registered and always consistent with the pointers after each edge.
- Push is accepted when `fifo_write` is high and the FIFO is not full, **or** when it is full and a pop is accepted in the same cycle.
- Pop is accepted when `fifo_read` is high and the FIFO is not empty.
  - A simultaneous push does not make an empty FIFO poppable: a write into an empty FIFO is not readable until the next cycle.
- Rejected push: data is dropped, pointers are unchanged, `overflow` is set.
- Rejected pop: `data_from_fifo` holds its last value, `underflow` is set.
- Simultaneous accepted push and pop: both pointers advance and level is unchanged.
- `flush`: both pointers go to 0 and `data_from_fifo` goes to 0.
  - Flush has priority over push and pop in the same cycle; the push is discarded and no error is flagged.
  - Flush does not clear `overflow`/`underflow`.
- `clear_status` clears both sticky flags. If an error occurs in the same cycle, the set wins.
- Reset (asynchronous, any time, including mid-burst) forces:
  - pointers = 0, `level` = 0, `fifo_empty` = 1, `fifo_full` = 0;
  - `almost_empty` = 1 (since AE_LEVEL ≥ 0), `almost_full` = 0;
  - `overflow` = `underflow` = 0, `data_from_fifo` = 0.
  - Contents are not cleared.

## Timing
- Write-to-read latency: a word pushed at edge N is poppable at edge N+1. `fifo_empty` deasserts after edge N.
- Read data latency is 1 cycle: a pop accepted at edge N drives `data_from_fifo` valid after edge N, held until the next accepted pop or flush.
- Flags update on the same edge as the pointer change. There is no combinational path from `fifo_write`/`fifo_read` to any output.
- Throughput: one push and one pop per cycle, sustained.
- The ADMA may sample `fifo_full`/`fifo_empty` and issue a request in the same cycle. Requests made against stale flags are handled by the reject rules above, never by corruption.

## Structure
- A shared package `adma_pkg` holds:
  - `ADMA_DATA_WIDTH` = 32;
  - default depth and thresholds;
  - a `fifo_status_t` struct {full, empty, almost_full, almost_empty, overflow, underflow} for the register block.
- Sub-module `adma_fifo_ram`: 1-write/1-read synchronous memory with registered read port. This keeps inference technology-neutral.
- Pointer, flag and sticky-status logic stays in `adma_data_fifo`.

## Test plan
- Reset with RESET=0 mid-burst (5 words stored) → all outputs at reset values immediately, before any clock edge. After release, `fifo_empty`=1 and `level`=0.
- Push 0x1000_0000..0x1000_000F (16 words) → `fifo_full`=1, `level`=16, `almost_full` first asserted at the 12th push. A 17th push sets `overflow` and `level` stays 16. Then pop all 16 → data returned in order, `fifo_empty`=1.
- At full, simultaneous push 0xDEAD_BEEF and pop → pop returns the oldest word, `level` stays 16, no `overflow`. 0xDEAD_BEEF is returned as the last of the next 16 pops.
- Empty FIFO, simultaneous push 0xA5A5_A5A5 and pop → `underflow`=1, `level`=1. The next-cycle pop returns 0xA5A5_A5A5.
- 40 push/pop pairs interleaved with level oscillating between 3 and 5 (pointer wrap crossed twice) → data order preserved, `almost_empty` toggles at level 4/5, no error flags.
- 7 words stored, `flush` asserted together with a push → `level`=0, `fifo_empty`=1, `data_from_fifo`=0, sticky flags unchanged. Then `clear_status` → `overflow`=`underflow`=0.

Source files
------------

// File: rtl/adma_pkg.sv
// Shared ADMA definitions: data width, default FIFO geometry and the
// status bundle exported to the host register block.
package adma_pkg;

  localparam int unsigned ADMA_DATA_WIDTH    = 32;
  localparam int unsigned ADMA_FIFO_DEPTH    = 16;
  localparam int unsigned ADMA_FIFO_AF_LEVEL = 12;
  localparam int unsigned ADMA_FIFO_AE_LEVEL = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/adma_fifo_ram.sv
// 1-write/1-read synchronous memory with a registered read port.
// The read register is resettable and clearable so the FIFO output
// can return to zero on reset or flush; the array itself is never reset.
module adma_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage write; same-address read in the same cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register next value: clear wins, otherwise load on read, else hold.
  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adma_data_fifo.sv
// Single-clock data FIFO between the ADMA engine and the SD data path.
// Pointers carry a wrap bit; all flags are registered from next-state pointers.
module adma_data_fifo
  import adma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADMA_DATA_WIDTH,
  parameter int unsigned DEPTH      = ADMA_FIFO_DEPTH,
  parameter int unsigned AF_LEVEL   = ADMA_FIFO_AF_LEVEL,
  parameter int unsigned AE_LEVEL   = ADMA_FIFO_AE_LEVEL
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   fifo_write,
  input  logic [DATA_WIDTH-1:0]  data_to_fifo,
  input  logic                   fifo_read,
  output logic [DATA_WIDTH-1:0]  data_from_fifo,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   flush,
  input  logic                   clear_status,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push_ok;
  logic          pop_ok;

  // Accept decisions, next pointers, next flags and sticky errors.
  // A push into a full FIFO is accepted only when a pop frees a slot in the
  // same cycle; the empty flag is registered, so a same-cycle push never
  // makes an empty FIFO poppable.
  always_comb begin
    pop_ok  = fifo_read && !empty_q;
    push_ok = fifo_write && (!full_q || pop_ok);
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push_ok) wp_d = wp_q + PW'(1);
      if (pop_ok)  rp_d = rp_q + PW'(1);
    end
    level_d = wp_d - rp_d;
    full_d  = (wp_d[AW-1:0] == rp_d[AW-1:0]) && (wp_d[AW] != rp_d[AW]);
    empty_d = (wp_d == rp_d);
    af_d    = (level_d >= PW'(AF_LEVEL));
    ae_d    = (level_d <= PW'(AE_LEVEL));
    ovf_d   = (ovf_q && !clear_status) || (fifo_write && !push_ok && !flush);
    unf_d   = (unf_q && !clear_status) || (fifo_read && !pop_ok && !flush);
  end

  // Pointer, flag and sticky-status registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  adma_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (flush),
    .we    (push_ok && !flush),
    .waddr (wp_q[AW-1:0]),
    .wdata (data_to_fifo),
    .re    (pop_ok && !flush),
    .raddr (rp_q[AW-1:0]),
    .rdata (data_from_fifo)
  );

  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_adma_data_fifo.sv
// Directed self-checking bench for adma_data_fifo.
module tb_adma_data_fifo;

  logic        CLK;
  logic        RESET;
  logic        fifo_write;
  logic [31:0] data_to_fifo;
  logic        fifo_read;
  logic [31:0] data_from_fifo;
  logic        fifo_full;
  logic        fifo_empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  level;
  logic        flush;
  logic        clear_status;
  logic        overflow;
  logic        underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  adma_data_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .AF_LEVEL   (12),
    .AE_LEVEL   (4)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .fifo_write     (fifo_write),
    .data_to_fifo   (data_to_fifo),
    .fifo_read      (fifo_read),
    .data_from_fifo (data_from_fifo),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .level          (level),
    .flush          (flush),
    .clear_status   (clear_status),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    fifo_write   = 1'b0;
    fifo_read    = 1'b0;
    flush        = 1'b0;
    clear_status = 1'b0;
    data_to_fifo = '0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    idle_inputs();
    step(); step();
    RESET = 1'b1;
    step();
    // pop on empty to get a sticky flag set before the reset
    fifo_read = 1'b1; step(); fifo_read = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL pre_reset_underflow got %b exp 1", underflow); end
    for (int i = 0; i < 5; i++) begin
      fifo_write = 1'b1; data_to_fifo = 32'h0B00_0000 + 32'(i); step();
    end
    fifo_write = 1'b0;
    fifo_read = 1'b1; step(); fifo_read = 1'b0;
    checks++;
    if (data_from_fifo !== 32'h0B00_0000) begin errors++; $display("FAIL pre_reset_data got %h exp %h", data_from_fifo, 32'h0B00_0000); end
    // mid-burst asynchronous reset, checked before the next edge
    fifo_write = 1'b1; data_to_fifo = 32'h0B00_0005; step();
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({level, fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow} !== {5'd0, 6'b101000}) begin
      errors++;
      $display("FAIL async_reset_flags got lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b exp lvl=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
               level, fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow);
    end
    checks++;
    if (data_from_fifo !== 32'h0) begin errors++; $display("FAIL async_reset_data got %h exp 0", data_from_fifo); end
    fifo_write = 1'b0;
    step();
    RESET = 1'b1;
    step();
    checks++;
    if (fifo_empty !== 1'b1 || level !== 5'd0) begin
      errors++; $display("FAIL post_reset got empty=%b level=%0d exp empty=1 level=0", fifo_empty, level);
    end
  endtask

  task automatic test_fill_drain();
    logic [4:0]  exp_lvl;
    logic        exp_af;
    logic [31:0] exp_data;
    for (int i = 0; i < 16; i++) begin
      fifo_write = 1'b1; data_to_fifo = 32'h1000_0000 + 32'(i); step();
      exp_lvl = 5'(i + 1);
      exp_af  = (i + 1 >= 12);
      checks++;
      if (level !== exp_lvl || almost_full !== exp_af) begin
        errors++; $display("FAIL fill_%0d got level=%0d af=%b exp level=%0d af=%b", i, level, almost_full, exp_lvl, exp_af);
      end
    end
    checks++;
    if (fifo_full !== 1'b1 || fifo_empty !== 1'b0) begin
      errors++; $display("FAIL fill_full got full=%b empty=%b exp full=1 empty=0", fifo_full, fifo_empty);
    end
    data_to_fifo = 32'h1000_0010; step(); fifo_write = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++; $display("FAIL overflow_push got ov=%b level=%0d exp ov=1 level=16", overflow, level);
    end
    clear_status = 1'b1; step(); clear_status = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow got %b exp 0", overflow); end
    fifo_read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_data = 32'h1000_0000 + 32'(i);
      checks++;
      if (data_from_fifo !== exp_data) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, data_from_fifo, exp_data); end
    end
    fifo_read = 1'b0;
    checks++;
    if (fifo_empty !== 1'b1 || level !== 5'd0 || underflow !== 1'b0) begin
      errors++; $display("FAIL drain_empty got empty=%b level=%0d un=%b exp empty=1 level=0 un=0", fifo_empty, level, underflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_data;
    for (int i = 0; i < 16; i++) begin
      fifo_write = 1'b1; data_to_fifo = 32'h2000_0000 + 32'(i); step();
    end
    data_to_fifo = 32'hDEAD_BEEF; fifo_read = 1'b1; step();
    fifo_write = 1'b0; fifo_read = 1'b0;
    checks++;
    if (data_from_fifo !== 32'h2000_0000 || level !== 5'd16 || overflow !== 1'b0 || fifo_full !== 1'b1) begin
      errors++; $display("FAIL full_pushpop got data=%h level=%0d ov=%b full=%b exp data=20000000 level=16 ov=0 full=1",
                         data_from_fifo, level, overflow, fifo_full);
    end
    fifo_read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_data = (i == 15) ? 32'hDEAD_BEEF : 32'h2000_0001 + 32'(i);
      checks++;
      if (data_from_fifo !== exp_data) begin errors++; $display("FAIL full_drain_%0d got %h exp %h", i, data_from_fifo, exp_data); end
    end
    fifo_read = 1'b0;
  endtask

  task automatic test_empty_push_pop();
    fifo_write = 1'b1; data_to_fifo = 32'hA5A5_A5A5; fifo_read = 1'b1; step();
    fifo_write = 1'b0; fifo_read = 1'b0;
    checks++;
    if (underflow !== 1'b1 || level !== 5'd1 || fifo_empty !== 1'b0 || data_from_fifo !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL empty_pushpop got un=%b level=%0d empty=%b data=%h exp un=1 level=1 empty=0 data=deadbeef",
                         underflow, level, fifo_empty, data_from_fifo);
    end
    fifo_read = 1'b1; step(); fifo_read = 1'b0;
    checks++;
    if (data_from_fifo !== 32'hA5A5_A5A5 || level !== 5'd0) begin
      errors++; $display("FAIL empty_next_pop got data=%h level=%0d exp data=a5a5a5a5 level=0", data_from_fifo, level);
    end
    clear_status = 1'b1; step(); clear_status = 1'b0;
  endtask

  task automatic test_interleave();
    logic [31:0] exp_q[$];
    logic [31:0] exp_data;
    int          lvl;
    int unsigned n;
    n = 0;
    lvl = 0;
    for (int i = 0; i < 3; i++) begin
      fifo_write = 1'b1; data_to_fifo = 32'h3000_0000 + 32'(n); exp_q.push_back(data_to_fifo); n++; step();
      lvl++;
    end
    fifo_write = 1'b0;
    for (int g = 0; g < 20; g++) begin
      for (int s = 0; s < 4; s++) begin
        if (s < 2) begin
          fifo_write = 1'b1; fifo_read = 1'b0;
          data_to_fifo = 32'h3000_0000 + 32'(n); exp_q.push_back(data_to_fifo); n++;
          lvl++;
        end else begin
          fifo_write = 1'b0; fifo_read = 1'b1;
          lvl--;
        end
        step();
        if (s >= 2) begin
          exp_data = exp_q.pop_front();
          checks++;
          if (data_from_fifo !== exp_data) begin errors++; $display("FAIL interleave_data_%0d_%0d got %h exp %h", g, s, data_from_fifo, exp_data); end
        end
        checks++;
        if (level !== 5'(lvl) || almost_empty !== (lvl <= 4)) begin
          errors++; $display("FAIL interleave_lvl_%0d_%0d got level=%0d ae=%b exp level=%0d ae=%b", g, s, level, almost_empty, lvl, (lvl <= 4));
        end
      end
    end
    fifo_write = 1'b0; fifo_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_data = exp_q.pop_front();
      checks++;
      if (data_from_fifo !== exp_data) begin errors++; $display("FAIL interleave_tail_%0d got %h exp %h", i, data_from_fifo, exp_data); end
    end
    fifo_read = 1'b0;
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL interleave_flags got ov=%b un=%b empty=%b exp ov=0 un=0 empty=1", overflow, underflow, fifo_empty);
    end
  endtask

  task automatic test_flush();
    fifo_read = 1'b1; step(); fifo_read = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL flush_pre_underflow got %b exp 1", underflow); end
    for (int i = 0; i < 8; i++) begin
      fifo_write = 1'b1; data_to_fifo = 32'h4000_0000 + 32'(i); step();
    end
    fifo_write = 1'b0;
    fifo_read = 1'b1; step(); fifo_read = 1'b0;
    checks++;
    if (data_from_fifo !== 32'h4000_0000 || level !== 5'd7) begin
      errors++; $display("FAIL flush_setup got data=%h level=%0d exp data=40000000 level=7", data_from_fifo, level);
    end
    flush = 1'b1; fifo_write = 1'b1; data_to_fifo = 32'h4000_00FF; step();
    flush = 1'b0; fifo_write = 1'b0;
    checks++;
    if (level !== 5'd0 || fifo_empty !== 1'b1 || almost_empty !== 1'b1 || data_from_fifo !== 32'h0) begin
      errors++; $display("FAIL flush_state got level=%0d empty=%b ae=%b data=%h exp level=0 empty=1 ae=1 data=0",
                         level, fifo_empty, almost_empty, data_from_fifo);
    end
    checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL flush_sticky got un=%b ov=%b exp un=1 ov=0", underflow, overflow);
    end
    step();
    checks++;
    if (level !== 5'd0 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL flush_push_dropped got level=%0d empty=%b exp level=0 empty=1", level, fifo_empty);
    end
    // clear and a new error in the same cycle: the set wins
    clear_status = 1'b1; fifo_read = 1'b1; step(); fifo_read = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL clear_vs_set got %b exp 1", underflow); end
    step(); clear_status = 1'b0;
    checks++;
    if (underflow !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL clear_status got un=%b ov=%b exp un=0 ov=0", underflow, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_empty_push_pop();
    test_interleave();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
